mac_bus_snoop: RTL and testbench

- Upstream stage of the video SRAM controller.
- Watches the asynchronous 68000 bus and detects completed word and byte writes that land in the Mac Plus main framebuffer.
- Converts each such write to a framebuffer-relative word address, data word and byte enables, and queues it in a small FIFO.
- The SRAM controller drains the FIFO through a valid/ready handshake in its write slots. The block replaces ad-hoc latching on the /AS edge with fully synchronous C25M-domain capture.

---
 rtl/mac_vga_pkg.sv | 20 ++
 rtl/snoop_fifo.sv | 58 +++++
 rtl/mac_bus_snoop.sv | 158 +++++++++++++++
 tb/tb_mac_bus_snoop.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_vga_pkg.sv
// Shared constants and the framebuffer write record used between the bus snoop
// and the video SRAM controller.
package mac_vga_pkg;

    localparam logic [23:0] FB_BASE_MAIN = 24'h3FA700;
    localparam int unsigned FB_WORDS     = 10944;
    localparam int          FB_AW        = 14;
    localparam int          DW           = 16;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [DW-1:0]    data;
        logic             nuds;
        logic             nlds;
    } fb_wr_t;

    // Value of an empty slot: no address, no data, both byte enables inactive.
    localparam fb_wr_t FB_WR_IDLE = '{addr: '0, data: '0, nuds: 1'b1, nlds: 1'b1};

endpackage

// File: rtl/snoop_fifo.sv
// Small show-ahead FIFO of framebuffer writes. The head entry is visible
// combinationally from registered storage; full/empty use an extra pointer bit.
module snoop_fifo
    import mac_vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  fb_wr_t push_data_i,
    output logic   push_ok_o,
    input  logic   pop_i,
    output fb_wr_t head_o,
    output logic   valid_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    fb_wr_t      mem_q [DEPTH];
    logic        full;
    logic        pop_ok;

    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign valid_o   = (wr_ptr_q != rd_ptr_q);
    assign pop_ok    = pop_i & valid_o;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok_o = push_i & (~full | pop_ok);

    assign wr_ptr_d = push_ok_o ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = pop_ok    ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;

    assign head_o = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= FB_WR_IDLE;
            end
        end else if (push_ok_o) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/mac_bus_snoop.sv
// Snoops 68000 writes into the Mac Plus main framebuffer and queues them,
// fully synchronous to C25M, for the video SRAM controller's write slots.
module mac_bus_snoop
    import mac_vga_pkg::fb_wr_t;
#(
    parameter logic [23:0] FB_BASE     = mac_vga_pkg::FB_BASE_MAIN,
    parameter int unsigned FB_WORDS    = mac_vga_pkg::FB_WORDS,
    parameter int          DEPTH       = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        C25M,
    input  logic        nRST,
    input  logic [23:1] A,
    input  logic [15:0] D,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        nWE,
    output logic        WrValid,
    input  logic        WrReady,
    output logic [13:0] WrA,
    output logic [15:0] WrD,
    output logic        WrnUDS,
    output logic        WrnLDS,
    output logic        Overflow
);

    localparam int          NSIG       = 4;
    localparam logic [22:0] FB_WORDS_W = 23'(FB_WORDS);

    logic [NSIG-1:0] bus_raw;
    logic [NSIG-1:0] bus_s;
    logic            nas_s, nuds_s, nlds_s, nwe_s;
    logic            nuds_p, nlds_p;

    assign bus_raw = {nWE, nLDS, nUDS, nAS};

    genvar gi;
    generate
        for (gi = 0; gi < NSIG; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;
            always_ff @(posedge C25M or negedge nRST) begin
                if (!nRST) begin
                    chain_q <= '1;
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], bus_raw[gi]};
                end
            end
            assign bus_s[gi] = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    assign nas_s  = bus_s[0];
    assign nuds_s = bus_s[1];
    assign nlds_s = bus_s[2];
    assign nwe_s  = bus_s[3];
    assign nuds_p = g_sync[1].chain_q[SYNC_STAGES-2];
    assign nlds_p = g_sync[2].chain_q[SYNC_STAGES-2];

    // The synchronizers come out of reset holding '1, not a real sample of /AS.
    // Arming waits until the chain is filled with genuine samples, so a bus
    // cycle already in progress at reset release can never be captured.
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   primed;

    always_ff @(posedge C25M or negedge nRST) begin
        if (!nRST) begin
            prime_q <= '0;
        end else begin
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
        end
    end
    assign primed = prime_q[SYNC_STAGES-1];

    logic armed_q, armed_d;
    logic capture;

    assign capture = armed_q & ~nas_s & ~nwe_s &
                     ((~nuds_s & ~nuds_p) | (~nlds_s & ~nlds_p));

    always_comb begin
        armed_d = armed_q;
        if (capture) begin
            armed_d = 1'b0;
        end else if (nas_s && primed) begin
            armed_d = 1'b1;
        end
    end

    logic        stg_vld_q;
    logic [23:1] stg_addr_q;
    logic [15:0] stg_data_q;
    logic        stg_nuds_q, stg_nlds_q;

    always_ff @(posedge C25M or negedge nRST) begin
        if (!nRST) begin
            armed_q    <= 1'b0;
            stg_vld_q  <= 1'b0;
            stg_addr_q <= '0;
            stg_data_q <= '0;
            stg_nuds_q <= 1'b1;
            stg_nlds_q <= 1'b1;
        end else begin
            armed_q   <= armed_d;
            stg_vld_q <= capture;
            if (capture) begin
                stg_addr_q <= A;
                stg_data_q <= D;
                stg_nuds_q <= nuds_s;
                stg_nlds_q <= nlds_s;
            end
        end
    end

    // Word-granular offset; bit 23 is the borrow of the subtraction.
    logic [23:0] word_off;
    logic        hit;
    fb_wr_t      push_data;
    fb_wr_t      head;
    logic        push_ok;

    assign word_off  = {1'b0, stg_addr_q} - {1'b0, FB_BASE[23:1]};
    assign hit       = stg_vld_q & ~word_off[23] & (word_off[22:0] < FB_WORDS_W);
    assign push_data = '{addr: word_off[13:0], data: stg_data_q,
                         nuds: stg_nuds_q, nlds: stg_nlds_q};

    snoop_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (C25M),
        .rst_ni      (nRST),
        .push_i      (hit),
        .push_data_i (push_data),
        .push_ok_o   (push_ok),
        .pop_i       (WrReady),
        .head_o      (head),
        .valid_o     (WrValid)
    );

    logic overflow_q, overflow_d;

    assign overflow_d = overflow_q | (hit & ~push_ok);

    always_ff @(posedge C25M or negedge nRST) begin
        if (!nRST) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign Overflow = overflow_q;
    assign WrA      = head.addr;
    assign WrD      = head.data;
    assign WrnUDS   = head.nuds;
    assign WrnLDS   = head.nlds;

endmodule

// File: tb/tb_mac_bus_snoop.sv
// Bench for mac_bus_snoop: directed bus cycles plus random traffic, checked
// against a queue of expected framebuffer writes derived from the bus activity.
module tb_mac_bus_snoop;

    localparam logic [23:0] BASE  = 24'h3FA700;
    localparam int          WORDS = 10944;

    logic        C25M = 1'b0;
    logic        nRST;
    logic [23:1] A;
    logic [15:0] D;
    logic        nAS, nUDS, nLDS, nWE;
    logic        WrReady;
    logic        WrValid;
    logic [13:0] WrA;
    logic [15:0] WrD;
    logic        WrnUDS, WrnLDS, Overflow;

    int          total = 0;
    int          bad   = 0;
    int          rdy_mode = 0;
    int          idle_run = 0;
    logic [31:0] exp_q[$];

    mac_bus_snoop dut (
        .C25M     (C25M),
        .nRST     (nRST),
        .A        (A),
        .D        (D),
        .nAS      (nAS),
        .nUDS     (nUDS),
        .nLDS     (nLDS),
        .nWE      (nWE),
        .WrValid  (WrValid),
        .WrReady  (WrReady),
        .WrA      (WrA),
        .WrD      (WrD),
        .WrnUDS   (WrnUDS),
        .WrnLDS   (WrnLDS),
        .Overflow (Overflow)
    );

    always #20 C25M = ~C25M;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Expected head record: {word offset, data, nUDS, nLDS}.
    function automatic logic [31:0] ent(input logic [23:0] addr, input logic [15:0] data,
                                        input logic u, input logic l);
        int unsigned w;
        w = (int'(addr) - int'(BASE)) / 2;
        return {w[13:0], data, u, l};
    endfunction

    function automatic bit is_hit(input logic [23:0] addr, input logic we_n,
                                  input logic u, input logic l, input int strobe_ns);
        return !we_n && (!u || !l) && strobe_ns >= 100 &&
               int'(addr) >= int'(BASE) && int'(addr) < int'(BASE) + 2 * WORDS;
    endfunction

    // WrReady: 0 = held low, 1 = held high, 2 = random but never low 3 cycles running.
    always @(posedge C25M) begin
        #1;
        case (rdy_mode)
            0: WrReady = 1'b0;
            1: WrReady = 1'b1;
            default: begin
                if (idle_run >= 2 || $urandom_range(0, 1) == 1) begin
                    WrReady  = 1'b1;
                    idle_run = 0;
                end else begin
                    WrReady  = 1'b0;
                    idle_run++;
                end
            end
        endcase
    end

    always @(negedge C25M) begin
        if (nRST === 1'b1 && WrValid === 1'b1 && WrReady === 1'b1) begin
            $display("pop a=%0d d=%h nuds=%b nlds=%b", WrA, WrD, WrnUDS, WrnLDS);
            check_val("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_val("pop_entry", {WrA, WrD, WrnUDS, WrnLDS}, exp_q.pop_front());
            end
        end
    end

    task automatic bus_cycle(input logic [23:0] addr, input logic [15:0] data, input logic we_n,
                             input logic u, input logic l, input int strobe_ns);
        @(posedge C25M);
        #7;
        A   = addr[23:1];
        D   = data;
        nWE = we_n;
        nAS = 1'b0;
        #30;
        nUDS = u;
        nLDS = l;
        #(strobe_ns);
        nUDS = 1'b1;
        nLDS = 1'b1;
        #20;
        nAS = 1'b1;
        nWE = 1'b1;
        repeat (8) @(posedge C25M);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge C25M);
            n++;
        end
        repeat (3) @(negedge C25M);
        check_val(tag, 32'(exp_q.size()), 32'd0);
        check_val({tag, "_idle"}, 32'(WrValid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(WrValid), 32'd0);
        check_val({tag, "_ovf"},   32'(Overflow), 32'd0);
        check_val({tag, "_wra"},   32'(WrA), 32'd0);
        check_val({tag, "_wrd"},   32'(WrD), 32'd0);
        check_val({tag, "_nuds"},  32'(WrnUDS), 32'd1);
        check_val({tag, "_nlds"},  32'(WrnLDS), 32'd1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] a;
        logic [15:0] d;
        logic        we_n, u, l;
        int          sel, sns;

        A = '0; D = '0; nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nWE = 1'b1;
        WrReady = 1'b0; nRST = 1'b0;
        repeat (3) @(posedge C25M);
        @(negedge C25M);
        check_reset_outputs("rst");
        @(posedge C25M);
        #7 nRST = 1'b1;
        repeat (6) @(posedge C25M);

        // Word write to the first framebuffer word, with capture latency check.
        a = BASE;
        @(posedge C25M);
        #7;
        A = a[23:1]; D = 16'hA5A5; nWE = 1'b0; nAS = 1'b0;
        @(posedge C25M);
        #7;
        nUDS = 1'b0; nLDS = 1'b0;
        exp_q.push_back(ent(a, 16'hA5A5, 1'b0, 1'b0));
        repeat (4) @(negedge C25M);
        check_val("lat_before", 32'(WrValid), 32'd0);
        @(negedge C25M);
        check_val("lat_valid", 32'(WrValid), 32'd1);
        check_val("word_head", {WrA, WrD, WrnUDS, WrnLDS}, exp_q[0]);
        #20;
        nUDS = 1'b1; nLDS = 1'b1;
        #20;
        nAS = 1'b1; nWE = 1'b1;
        rdy_mode = 1;
        wait_drain("word_drain");

        // Last word as a lower-byte write, then one past the end and one below.
        exp_q.push_back(ent(24'h3FFC7E, 16'h5A3C, 1'b1, 1'b0));
        bus_cycle(24'h3FFC7E, 16'h5A3C, 1'b0, 1'b1, 1'b0, 200);
        bus_cycle(24'h3FFC80, 16'h1111, 1'b0, 1'b0, 1'b0, 200);
        bus_cycle(24'h3FA6FE, 16'h2222, 1'b0, 1'b0, 1'b0, 200);
        wait_drain("edge_drain");
        check_val("edge_ovf", 32'(Overflow), 32'd0);

        // Read cycle and a short strobe glitch.
        bus_cycle(24'h3FA800, 16'h3333, 1'b1, 1'b0, 1'b0, 200);
        bus_cycle(24'h3FA800, 16'h4444, 1'b0, 1'b0, 1'b0, 30);
        wait_drain("rd_glitch");

        // Five hits with the consumer stalled: four kept, fifth dropped.
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            a = BASE + 24'(2 * (100 + i * 7));
            d = 16'h1000 + 16'(i);
            if (i < 4) exp_q.push_back(ent(a, d, 1'b0, 1'b0));
            bus_cycle(a, d, 1'b0, 1'b0, 1'b0, 200);
        end
        repeat (4) @(negedge C25M);
        check_val("ovf_set", 32'(Overflow), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge C25M);
            check_val("stall_valid", 32'(WrValid), 32'd1);
            check_val("stall_head", {WrA, WrD, WrnUDS, WrnLDS}, exp_q[0]);
        end
        rdy_mode = 1;
        @(posedge C25M);
        for (int i = 0; i < 4; i++) begin
            @(negedge C25M);
            check_val("drain_run", 32'(WrValid), 32'd1);
        end
        @(negedge C25M);
        check_val("drain_end", 32'(WrValid), 32'd0);
        check_val("drain_left", 32'(exp_q.size()), 32'd0);

        // Reset mid-queue, released during a write that must not be captured.
        rdy_mode = 0;
        for (int i = 0; i < 2; i++) begin
            a = BASE + 24'(2 * (500 + i));
            exp_q.push_back(ent(a, 16'hBEE0 + 16'(i), 1'b0, 1'b0));
            bus_cycle(a, 16'hBEE0 + 16'(i), 1'b0, 1'b0, 1'b0, 200);
        end
        repeat (4) @(negedge C25M);
        check_val("preq_valid", 32'(WrValid), 32'd1);
        @(posedge C25M);
        #7 nRST = 1'b0;
        exp_q.delete();
        #5;
        check_reset_outputs("rst2");
        a = BASE + 24'h40;
        A = a[23:1]; D = 16'hDEAD; nWE = 1'b0; nAS = 1'b0;
        #30;
        nUDS = 1'b0; nLDS = 1'b0;
        #200 nRST = 1'b1;
        repeat (15) @(posedge C25M);
        #7;
        nUDS = 1'b1; nLDS = 1'b1;
        #20;
        nAS = 1'b1; nWE = 1'b1;
        repeat (10) @(negedge C25M);
        check_val("rst_no_capture", 32'(WrValid), 32'd0);
        rdy_mode = 1;
        a = BASE + 24'h80;
        exp_q.push_back(ent(a, 16'hC0DE, 1'b0, 1'b0));
        bus_cycle(a, 16'hC0DE, 1'b0, 1'b0, 1'b0, 200);
        wait_drain("post_rst");

        // Long write: /AS held 2 us with the upper strobe low throughout.
        a = BASE + 24'h1234;
        exp_q.push_back(ent(a, 16'h7E57, 1'b0, 1'b1));
        bus_cycle(a, 16'h7E57, 1'b0, 1'b0, 1'b1, 2000);
        wait_drain("long");

        // Random traffic with a consumer that sometimes stalls.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = BASE + 24'(2 * $urandom_range(0, WORDS - 1));
            else if (sel == 6) a = BASE - 24'(2 * $urandom_range(1, 200));
            else if (sel == 7) a = BASE + 24'(2 * (WORDS + $urandom_range(0, 200)));
            else if (sel == 8) begin
                a = 24'($urandom);
                a[0] = 1'b0;
            end else begin
                case ($urandom_range(0, 3))
                    0: a = BASE;
                    1: a = BASE + 24'(2 * (WORDS - 1));
                    2: a = BASE - 24'd2;
                    default: a = BASE + 24'(2 * WORDS);
                endcase
            end
            d    = 16'($urandom);
            we_n = ($urandom_range(0, 4) == 0);
            sel  = $urandom_range(0, 2);
            u    = (sel == 2);
            l    = (sel == 1);
            sns  = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(100, 400);
            if (is_hit(a, we_n, u, l, sns)) exp_q.push_back(ent(a, d, u, l));
            bus_cycle(a, d, we_n, u, l, sns);
        end
        wait_drain("rand");
        check_val("rand_ovf", 32'(Overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
